biss_frame_checker: RTL and testbench
=====================================

Name: biss_frame_checker

Overview:
- Sits directly downstream of the BiSS-C serial receiver and consumes its captured 40-bit frame.
- Frame layout: 32-bit position, error bit, warning bit, 6-bit CRC.
- Recomputes the BiSS CRC6 serially, checks it against the received value, and publishes only CRC-good positions.
- Flags encoder error/warning, counts CRC failures, declares a fault after consecutive failures and runs a frame-timeout watchdog for the motion controller.

Parameters:
- TIMEOUT_CYCLES, 100000, clk cycles without an accepted frame before timeout asserts.
- MAX_CONSEC_ERR, 4, consecutive CRC failures that assert fault.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frame_in  in  40  [39:8] position, [7] nE (error, active-low), [6] nW (warning, active-low), [5:0] received CRC (transmitted inverted)
- frame_valid  in  1  one-cycle strobe, frame_in stable in that cycle
- pos_out  out  32  last CRC-good position
- pos_valid  out  1  one-cycle pulse when pos_out updates
- crc_err  out  1  one-cycle pulse on CRC mismatch
- enc_error  out  1  ~nE of last CRC-good frame
- enc_warn  out  1  ~nW of last CRC-good frame
- crc_err_cnt  out  16  saturating CRC failure count
- overrun  out  1  one-cycle pulse when frame_valid arrives while busy
- fault  out  1  consecutive CRC failures >= MAX_CONSEC_ERR
- timeout  out  1  watchdog expired
- busy  out  1  high in CALC/CHECK

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - reset is synchronous and active-high.
  - Every output and internal register resets to 0, including the watchdog counter and the consecutive-error counter.
- CRC definition:
  - Polynomial x^6+x+1 (0x43), init 6'b000000.
  - Computed over the 34 data bits frame_in[39:6], MSB first.
  - Expected value is ~crc, compared to frame_in[5:0].
- State machine, states IDLE, CALC, CHECK:
  - IDLE: on frame_valid, latch frame_in into shift/hold registers, clear the CRC register, set bit counter to 33, go to CALC.
  - CALC: one data bit per cycle, shifting the MSB out: fb = crc[5]^bit; crc <= {crc[4:0],1'b0} ^ (fb ? 6'h03 : 6'h00). Bit counter decrements; after the bit at count 0 is processed, go to CHECK. CALC lasts exactly 34 cycles.
  - CHECK, one cycle, then return to IDLE:
    - On match: the next cycle sets pos_out = latched [39:8], enc_error = ~[7], enc_warn = ~[6], pulses pos_valid, and clears the consecutive counter.
    - On mismatch: pulses crc_err, increments crc_err_cnt (saturating at 16'hFFFF), increments the consecutive counter (saturating at MAX_CONSEC_ERR).
- Latency: frame_valid at cycle 0 gives pos_valid or crc_err at cycle 36.
- Held outputs: pos_out, enc_error and enc_warn hold their values across CRC failures.
- Fault: combinational compare of the consecutive counter >= MAX_CONSEC_ERR, registered. Cleared only by a CRC-good frame or reset.
- Overrun: frame_valid while busy=1 is dropped and pulses overrun. The in-flight check is unaffected.
- Watchdog:
  - Counter increments every cycle and saturates at TIMEOUT_CYCLES.
  - Cleared on any accepted frame_valid, good or bad.
  - timeout = (counter == TIMEOUT_CYCLES).
  - timeout deasserts on the cycle after an accepted frame.
- Simultaneous events:
  - frame_valid in the same cycle as the CHECK→IDLE transition is overrun; it is accepted only in IDLE.
  - reset has priority over everything and aborts any in-flight frame with no pulse output.

Optional Feature:
- Macro: BISS_VELOCITY_EN.
- When defined, adds output vel_out (signed 32) and vel_valid (1).
  - On each CRC-good frame after the first good one since reset: vel_out = pos_new - pos_prev in 32-bit two's complement, so 0x00000002 - 0xFFFFFFFE = +4. This keeps single-turn wrap correct.
  - vel_valid pulses in the same cycle as pos_valid.
  - The first good frame after reset gives no vel_valid.
- When undefined, the ports and logic are absent.

Decomposition:
- Shared package biss_pkg holds:
  - constants: BISS_FRAME_W=40, BISS_POS_W=32, BISS_CRC_W=6, BISS_CRC_POLY=6'h03 (x^6 implicit), BISS_DATA_W=34, field bit offsets
  - the state encoding typedef
- One natural sub-module: biss_crc6_serial (clear, bit_in, bit_en → crc[5:0]), reusable by a future BiSS register-channel block.

Test Plan:
- Good frame: frame_in=40'h00_0000_003F (data 0, CRC 0 inverted), frame_valid pulse → pos_valid at cycle 36, pos_out=0, enc_error=1, enc_warn=1, crc_err=0.
- Bad CRC: frame_in=40'h00_0000_0000 → crc_err pulse at cycle 36, crc_err_cnt=1, pos_out unchanged; four in a row → fault=1; then the good frame above → fault=0.
- Overrun: second frame_valid 10 cycles after the first → overrun pulse, exactly one result pulse, busy high for 35 cycles.
- Watchdog: with TIMEOUT_CYCLES=50, no frames for 50 cycles → timeout=1; a frame at cycle 60 → timeout=0 at cycle 61.
- Reset mid-CALC: assert reset at cycle 20 of a good frame → no pos_valid, all outputs 0, busy=0.
- BISS_VELOCITY_EN: good frames with position 0xFFFFFFFE then 0x00000002 (CRCs from the reference model) → vel_out=+4 with vel_valid on the second only.

Source files
------------

// File: rtl/biss_frame_checker_pkg.sv
// biss_pkg: shared BiSS-C frame constants and checker state encoding
package biss_pkg;
  localparam int BISS_FRAME_W = 40;
  localparam int BISS_POS_W = 32;
  localparam int BISS_CRC_W = 6;
  localparam logic [BISS_CRC_W-1:0] BISS_CRC_POLY = 6'h03;
  localparam int BISS_DATA_W = 34;
  localparam int BISS_POS_LSB = 8;
  localparam int BISS_NE_BIT = 7;
  localparam int BISS_NW_BIT = 6;
  localparam int BISS_DATA_LSB = 6;
  typedef enum logic [1:0] {IDLE, CALC, CHECK} biss_state_e;
endpackage

// File: rtl/biss_frame_checker_if.sv
// biss_frame_checker_if: frame strobe from the BiSS receiver and checker results
// master: receiver/controller side (drives frame_in, frame_valid)
// slave: checker side (drives pos_out, pos_valid, crc_err, enc_error, enc_warn,
//   crc_err_cnt, overrun, fault, timeout, busy; vel_out, vel_valid with BISS_VELOCITY_EN)
interface biss_frame_checker_if;
  import biss_pkg::*;
  logic [BISS_FRAME_W-1:0] frame_in;
  logic frame_valid;
  logic [BISS_POS_W-1:0] pos_out;
  logic pos_valid;
  logic crc_err;
  logic enc_error;
  logic enc_warn;
  logic [15:0] crc_err_cnt;
  logic overrun;
  logic fault;
  logic timeout;
  logic busy;
`ifdef BISS_VELOCITY_EN
  logic signed [BISS_POS_W-1:0] vel_out;
  logic vel_valid;
`endif
  modport master (
`ifdef BISS_VELOCITY_EN
    input vel_out, vel_valid,
`endif
    output frame_in, frame_valid,
    input pos_out, pos_valid, crc_err, enc_error, enc_warn, crc_err_cnt, overrun, fault, timeout, busy
  );
  modport slave (
`ifdef BISS_VELOCITY_EN
    output vel_out, vel_valid,
`endif
    input frame_in, frame_valid,
    output pos_out, pos_valid, crc_err, enc_error, enc_warn, crc_err_cnt, overrun, fault, timeout, busy
  );
endinterface

// File: rtl/biss_frame_checker_crc6_serial.sv
// biss_crc6_serial: bit-serial BiSS CRC6 (x^6+x+1, init 0, MSB first)
// clk, reset: clock and synchronous active-high reset
// clear_i: zero the CRC (wins over bit_en_i); bit_in_i/bit_en_i: next data bit and its enable
// crc_o: current CRC register (not inverted)
module biss_crc6_serial
  import biss_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  bit_in_i,
  input  logic                  bit_en_i,
  output logic [BISS_CRC_W-1:0] crc_o
);
  logic [BISS_CRC_W-1:0] crc_q, crc_d;
  logic fb;
  always_comb begin
    fb = crc_q[BISS_CRC_W-1] ^ bit_in_i;
    crc_d = clear_i ? '0 :
            bit_en_i ? ({crc_q[BISS_CRC_W-2:0], 1'b0} ^ (fb ? BISS_CRC_POLY : '0)) : crc_q;
  end
  always_ff @(posedge clk)
    if (reset) crc_q <= '0;
    else crc_q <= crc_d;
  assign crc_o = crc_q;
endmodule

// File: rtl/biss_frame_checker.sv
// biss_frame_checker: CRC-checks BiSS-C frames, publishes good positions, tracks errors and watchdog
// clk, reset: clock and synchronous active-high reset
// bus (slave): frame_in/frame_valid in; pos/status/error/watchdog results out
// Optional: define BISS_VELOCITY_EN to add vel_out/vel_valid (position delta between good frames)
module biss_frame_checker
  import biss_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_CONSEC_ERR = 4
) (
  input logic clk,
  input logic reset,
  biss_frame_checker_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CE_W = $clog2(MAX_CONSEC_ERR + 1);
  biss_state_e state_q;
  logic [5:0] bit_cnt_q;
  logic [BISS_DATA_W-1:0] shift_q;
  logic [BISS_FRAME_W-1:0] hold_q;
  logic [BISS_POS_W-1:0] pos_q;
  logic pos_valid_q, crc_err_q, enc_error_q, enc_warn_q, overrun_q, fault_q;
  logic [15:0] err_cnt_q;
  logic [CE_W-1:0] consec_q, consec_d;
  logic [WD_W-1:0] wd_q;
  logic [BISS_CRC_W-1:0] crc;
  logic accept, crc_ok;
`ifdef BISS_VELOCITY_EN
  logic [BISS_POS_W-1:0] vel_q;
  logic vel_valid_q, have_pos_q;
`endif
  assign accept = bus.frame_valid && state_q == IDLE;
  assign crc_ok = ~crc == hold_q[BISS_CRC_W-1:0];
  biss_crc6_serial u_crc (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (accept),
    .bit_in_i (shift_q[BISS_DATA_W-1]),
    .bit_en_i (state_q == CALC),
    .crc_o    (crc)
  );
  always_comb
    consec_d = state_q != CHECK ? consec_q :
               crc_ok ? '0 :
               consec_q == CE_W'(MAX_CONSEC_ERR) ? consec_q : consec_q + 1'b1;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      bit_cnt_q <= '0;
      shift_q <= '0;
      hold_q <= '0;
      pos_q <= '0;
      pos_valid_q <= 1'b0;
      crc_err_q <= 1'b0;
      enc_error_q <= 1'b0;
      enc_warn_q <= 1'b0;
      overrun_q <= 1'b0;
      fault_q <= 1'b0;
      err_cnt_q <= '0;
      consec_q <= '0;
      wd_q <= '0;
`ifdef BISS_VELOCITY_EN
      vel_q <= '0;
      vel_valid_q <= 1'b0;
      have_pos_q <= 1'b0;
`endif
    end else begin
      pos_valid_q <= 1'b0;
      crc_err_q <= 1'b0;
      overrun_q <= bus.frame_valid && state_q != IDLE;
      consec_q <= consec_d;
      fault_q <= consec_d >= CE_W'(MAX_CONSEC_ERR);
      wd_q <= accept ? '0 : wd_q == WD_W'(TIMEOUT_CYCLES) ? wd_q : wd_q + 1'b1;
`ifdef BISS_VELOCITY_EN
      vel_valid_q <= 1'b0;
`endif
      case (state_q)
        IDLE:
          if (bus.frame_valid) begin
            hold_q <= bus.frame_in;
            shift_q <= bus.frame_in[BISS_FRAME_W-1:BISS_DATA_LSB];
            bit_cnt_q <= 6'(BISS_DATA_W - 1);
            state_q <= CALC;
          end
        CALC: begin
          shift_q <= {shift_q[BISS_DATA_W-2:0], 1'b0};
          bit_cnt_q <= bit_cnt_q - 1'b1;
          if (bit_cnt_q == '0) state_q <= CHECK;
        end
        CHECK: begin
          state_q <= IDLE;
          if (crc_ok) begin
            pos_q <= hold_q[BISS_FRAME_W-1:BISS_POS_LSB];
            enc_error_q <= ~hold_q[BISS_NE_BIT];
            enc_warn_q <= ~hold_q[BISS_NW_BIT];
            pos_valid_q <= 1'b1;
`ifdef BISS_VELOCITY_EN
            // modular difference keeps single-turn wrap-around correct
            vel_q <= hold_q[BISS_FRAME_W-1:BISS_POS_LSB] - pos_q;
            vel_valid_q <= have_pos_q;
            have_pos_q <= 1'b1;
`endif
          end else begin
            crc_err_q <= 1'b1;
            err_cnt_q <= &err_cnt_q ? err_cnt_q : err_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.pos_out = pos_q;
  assign bus.pos_valid = pos_valid_q;
  assign bus.crc_err = crc_err_q;
  assign bus.enc_error = enc_error_q;
  assign bus.enc_warn = enc_warn_q;
  assign bus.crc_err_cnt = err_cnt_q;
  assign bus.overrun = overrun_q;
  assign bus.fault = fault_q;
  assign bus.timeout = wd_q == WD_W'(TIMEOUT_CYCLES);
  assign bus.busy = state_q != IDLE;
`ifdef BISS_VELOCITY_EN
  assign bus.vel_out = vel_q;
  assign bus.vel_valid = vel_valid_q;
`endif
endmodule

// File: tb/tb_biss_frame_checker.sv
// tb_biss_frame_checker: scoreboard bench for biss_frame_checker (TIMEOUT_CYCLES=50)
module tb_biss_frame_checker;
  import biss_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  typedef struct {
    int cyc;
    logic good;
    logic [31:0] pos;
    logic err;
    logic warn;
    logic [15:0] cnt;
    logic fault;
    logic vv;
    logic [31:0] vel;
  } exp_t;
  exp_t q[$];
  logic [31:0] m_pos;
  logic m_err, m_warn, m_have;
  logic [15:0] m_cnt;
  int m_consec;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  biss_frame_checker_if bus ();
  biss_frame_checker #(.TIMEOUT_CYCLES(50), .MAX_CONSEC_ERR(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  // CRC as the remainder of data*x^6 divided by x^6+x+1
  function automatic logic [5:0] crc6(input logic [33:0] d);
    logic [39:0] r;
    r = {d, 6'b0};
    for (int i = 39; i >= 6; i--) if (r[i]) r[i-:7] = r[i-:7] ^ 7'h43;
    return r[5:0];
  endfunction
  function automatic logic [39:0] mk(input logic [31:0] pos, input logic ne, input logic nw);
    logic [33:0] d;
    d = {pos, ne, nw};
    return {d, ~crc6(d)};
  endfunction
  task automatic model_reset();
    m_pos = '0; m_err = 0; m_warn = 0; m_have = 0; m_cnt = '0; m_consec = 0;
  endtask
  // mode 0: accepted, 1: dropped as overrun, 2: accepted but will be aborted by reset
  task automatic send(input logic [39:0] f, input int mode);
    exp_t e;
    @(negedge clk);
    bus.frame_in = f;
    bus.frame_valid = 1'b1;
    if (mode == 0) begin
      e.cyc = cyc + 36;
      e.good = ~crc6(f[39:6]) == f[5:0];
      e.vv = 1'b0;
      e.vel = '0;
      if (e.good) begin
        e.vel = f[39:8] - m_pos;
        e.vv = m_have;
        m_pos = f[39:8]; m_err = ~f[7]; m_warn = ~f[6]; m_consec = 0; m_have = 1'b1;
      end else begin
        m_cnt = m_cnt == 16'hFFFF ? m_cnt : m_cnt + 16'd1;
        m_consec = m_consec >= 4 ? 4 : m_consec + 1;
      end
      e.pos = m_pos; e.err = m_err; e.warn = m_warn; e.cnt = m_cnt; e.fault = m_consec >= 4;
      q.push_back(e);
    end
    @(negedge clk);
    bus.frame_valid = 1'b0;
    check("overrun", bus.overrun, mode == 1);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 80 && q.size() != 0; i++) @(negedge clk);
    check("result_drain", q.size(), 0);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_pos_out"}, bus.pos_out, 0);
    check({tag, "_pos_valid"}, bus.pos_valid, 0);
    check({tag, "_crc_err"}, bus.crc_err, 0);
    check({tag, "_enc_error"}, bus.enc_error, 0);
    check({tag, "_enc_warn"}, bus.enc_warn, 0);
    check({tag, "_crc_err_cnt"}, bus.crc_err_cnt, 0);
    check({tag, "_overrun"}, bus.overrun, 0);
    check({tag, "_fault"}, bus.fault, 0);
    check({tag, "_timeout"}, bus.timeout, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.pos_valid || bus.crc_err) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: pos_valid=%0b crc_err=%0b with nothing expected (cycle %0d)",
                 bus.pos_valid, bus.crc_err, cyc);
      end else begin
        e = q.pop_front();
        check("latency_cycle", cyc, e.cyc);
        check("pos_valid", bus.pos_valid, e.good);
        check("crc_err", bus.crc_err, !e.good);
        check("pos_out", bus.pos_out, e.pos);
        check("enc_error", bus.enc_error, e.err);
        check("enc_warn", bus.enc_warn, e.warn);
        check("crc_err_cnt", bus.crc_err_cnt, e.cnt);
        check("fault", bus.fault, e.fault);
`ifdef BISS_VELOCITY_EN
        check("vel_valid", bus.vel_valid, e.vv);
        if (e.vv) check("vel_out", bus.vel_out, e.vel);
`endif
      end
    end
`ifdef BISS_VELOCITY_EN
    else if (bus.vel_valid) begin
      n_chk++;
      $display("FAIL vel_valid_alone: got 1 expected 0 (cycle %0d)", cyc);
    end
`endif
  end
  initial begin
    int c0, b;
    bus.frame_in = '0;
    bus.frame_valid = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    c0 = cyc;
    repeat (49) @(negedge clk);
    check("timeout_before", bus.timeout, 0);
    @(negedge clk);
    check("timeout_at_50", bus.timeout, 1);
    repeat (9) @(negedge clk);
    check("timeout_held", bus.timeout, 1);
    send(40'h00_0000_003F, 0);
    check("timeout_cleared", bus.timeout, 0);
    check("frame_at_cycle_60", cyc - c0, 61);
    b = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.busy) b++;
      @(negedge clk);
    end
    check("busy_cycles", b, 35);
    wait_done();
    send(mk(32'h1234_5678, 1'b1, 1'b0), 0);
    wait_done();
    send(mk(32'hFFFF_FFFE, 1'b0, 1'b1), 0);
    wait_done();
    repeat (4) begin
      send(40'h00_0000_0000, 0);
      wait_done();
    end
    send(40'h00_0000_003F, 0);
    wait_done();
    send(mk(32'hA5A5_0001, 1'b1, 1'b1), 0);
    repeat (8) @(negedge clk);
    send(mk(32'h0BAD_0BAD, 1'b1, 1'b1), 1);
    repeat (23) @(negedge clk);
    check("busy_in_check", bus.busy, 1);
    send(mk(32'h0BAD_0BAE, 1'b1, 1'b1), 1);
    wait_done();
    repeat (40) @(negedge clk);
    send(mk(32'hDEAD_BEEF, 1'b0, 1'b0), 2);
    repeat (18) @(negedge clk);
    check("busy_mid_calc", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_zero("abort");
    repeat (45) @(negedge clk);
    check("abort_pos_out", bus.pos_out, 0);
    send(mk(32'hFFFF_FFFE, 1'b1, 1'b1), 0);
    wait_done();
    send(mk(32'h0000_0002, 1'b1, 1'b1), 0);
    wait_done();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
